// File: rtl/psum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_pkg: mode encodings, FSM states and lane saturating add          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package psum_pkg;

  localparam logic [1:0] MODE_WRITE = 2'd0;
  localparam logic [1:0] MODE_ACCUM = 2'd1;
  localparam logic [1:0] MODE_READ  = 2'd2;

  // Widest lane the saturating adder supports; lanes are sign-extended to this.
  localparam int PSUM_MAX_BW = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_AC_RD = 3'd2,
    S_AC_WB = 3'd3,
    S_RD    = 3'd4
  } state_t;

  // Returns {saturated, result}; result is valid in its low bw bits.
  function automatic logic [PSUM_MAX_BW:0] sat_add(
    input logic signed [PSUM_MAX_BW-1:0] a,
    input logic signed [PSUM_MAX_BW-1:0] b,
    input int                            bw
  );
    logic signed [PSUM_MAX_BW:0] s;
    logic signed [PSUM_MAX_BW:0] one;
    logic signed [PSUM_MAX_BW:0] hi;
    logic signed [PSUM_MAX_BW:0] lo;
    one    = '0;
    one[0] = 1'b1;
    s      = {a[PSUM_MAX_BW-1], a} + {b[PSUM_MAX_BW-1], b};
    hi     = (one <<< (bw - 1)) - one;
    lo     = -(one <<< (bw - 1));
    if (s > hi) begin
      sat_add = {1'b1, hi[PSUM_MAX_BW-1:0]};
    end else if (s < lo) begin
      sat_add = {1'b1, lo[PSUM_MAX_BW-1:0]};
    end else begin
      sat_add = {1'b0, s[PSUM_MAX_BW-1:0]};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_sram_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_sram_bank: single-port SRAM, active-low CEN/WEN, 1-cycle read    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module psum_sram_bank #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cen,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_d,
  output logic [WIDTH-1:0]  o_q
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] r_q;

  // Array contents are deliberately not reset so they survive a burst abort.
  always_ff @(posedge clk) begin
    if (!i_cen && !i_wen) begin
      r_mem[i_addr] <= i_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (!i_cen && i_wen) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/psum_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_accum_ctrl: burst write / accumulate / read psum buffer control  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module psum_accum_ctrl
  import psum_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W:0]        len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*PSUM_BW-1:0] in_data,
  output logic                   out_valid,
  output logic [COL*PSUM_BW-1:0] out_data,
  output logic                   busy,
  output logic                   done,
  output logic [COL-1:0]         ovf,
  input  logic                   user_mode,
  input  logic                   ext_cen,
  input  logic                   ext_wen,
  input  logic [ADDR_W-1:0]      ext_addr,
  input  logic [COL*PSUM_BW-1:0] ext_d
);

  localparam int WIDTH = COL * PSUM_BW;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W:0]    r_ctr;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W-1:0]  r_addr;
  logic [COL-1:0]     r_ovf;
  logic               r_done;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_in_data;

  logic               w_last;
  logic               w_start_acc;
  logic               w_step;
  logic               w_cap;
  logic               w_done_nxt;
  logic               w_in_ready;
  logic               w_fsm_cen;
  logic               w_fsm_wen;
  logic [WIDTH-1:0]   w_fsm_d;
  logic [WIDTH-1:0]   w_sum;
  logic [COL-1:0]     w_sat;

  logic               w_user;
  logic               w_sram_cen;
  logic               w_sram_wen;
  logic [ADDR_W-1:0]  w_sram_addr;
  logic [WIDTH-1:0]   w_sram_d;
  logic [WIDTH-1:0]   w_sram_q;
  logic               w_rd_issue;

  assign w_last = ((r_ctr + 1'b1) == r_len);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_step      = 1'b0;
    w_cap       = 1'b0;
    w_done_nxt  = 1'b0;
    w_in_ready  = 1'b0;
    w_fsm_cen   = 1'b1;
    w_fsm_wen   = 1'b1;
    w_fsm_d     = in_data;
    case (r_state)
      S_IDLE: begin
        if (start && (mode != 2'd3)) begin
          w_start_acc = 1'b1;
          if (len == '0) begin
            w_done_nxt = 1'b1;
          end else if (mode == MODE_WRITE) begin
            w_state_nxt = S_WR;
          end else if (mode == MODE_ACCUM) begin
            w_state_nxt = S_AC_RD;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_WR: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_fsm_cen = 1'b0;
          w_fsm_wen = 1'b0;
          w_step    = 1'b1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_AC_RD: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_fsm_cen   = 1'b0;
          w_cap       = 1'b1;
          w_state_nxt = S_AC_WB;
        end
      end
      S_AC_WB: begin
        w_fsm_cen = 1'b0;
        w_fsm_wen = 1'b0;
        w_fsm_d   = w_sum;
        w_step    = 1'b1;
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_AC_RD;
        end
      end
      S_RD: begin
        w_fsm_cen = 1'b0;
        w_step    = 1'b1;
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctr       <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_ovf       <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_data   <= '0;
    end else begin
      r_done      <= w_done_nxt;
      r_out_valid <= w_rd_issue;
      if (w_start_acc) begin
        r_ctr  <= '0;
        r_len  <= len;
        r_addr <= base_addr;
        r_ovf  <= '0;
      end else begin
        if (w_step) begin
          r_ctr  <= r_ctr + 1'b1;
          r_addr <= r_addr + 1'b1;
        end
        if (r_state == S_AC_WB) begin
          r_ovf <= r_ovf | w_sat;
        end
      end
      if (w_cap) begin
        r_in_data <= in_data;
      end
    end
  end

  for (genvar gi = 0; gi < COL; gi++) begin : g_lane
    logic signed [PSUM_BW-1:0] w_q_lane;
    logic signed [PSUM_BW-1:0] w_in_lane;
    logic [PSUM_MAX_BW:0]      w_res;
    logic                      w_unused_hi;
    assign w_q_lane    = w_sram_q[gi*PSUM_BW +: PSUM_BW];
    assign w_in_lane   = r_in_data[gi*PSUM_BW +: PSUM_BW];
    assign w_res       = sat_add(PSUM_MAX_BW'(w_q_lane), PSUM_MAX_BW'(w_in_lane), PSUM_BW);
    assign w_unused_hi = ^w_res[PSUM_MAX_BW-1:PSUM_BW];
    assign w_sum[gi*PSUM_BW +: PSUM_BW] = w_res[PSUM_BW-1:0];
    assign w_sat[gi]   = w_res[PSUM_MAX_BW];
  end

  // External port owns the SRAM only while idle; reset blocks any access.
  assign w_user      = (r_state == S_IDLE) && user_mode;
  assign w_sram_cen  = reset | (w_user ? ext_cen : w_fsm_cen);
  assign w_sram_wen  = w_user ? ext_wen  : w_fsm_wen;
  assign w_sram_addr = w_user ? ext_addr : r_addr;
  assign w_sram_d    = w_user ? ext_d    : w_fsm_d;
  assign w_rd_issue  = !w_sram_cen && w_sram_wen && (w_user || (r_state == S_RD));

  psum_sram_bank #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .i_cen  (w_sram_cen),
    .i_wen  (w_sram_wen),
    .i_addr (w_sram_addr),
    .i_d    (w_sram_d),
    .o_q    (w_sram_q)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_sram_q;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_psum_accum_ctrl: directed self-checking bench for psum_accum_ctrl  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_psum_accum_ctrl;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_W  = 11;
  localparam int W       = COL * PSUM_BW;

  logic              clk;
  logic              reset;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              busy;
  logic              done;
  logic [COL-1:0]    ovf;
  logic              user_mode;
  logic              ext_cen;
  logic              ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [W-1:0]      ext_d;

  int n_pass  = 0;
  int n_total = 0;

  psum_accum_ctrl #(.COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .len(len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done), .ovf(ovf),
    .user_mode(user_mode), .ext_cen(ext_cen), .ext_wen(ext_wen),
    .ext_addr(ext_addr), .ext_d(ext_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ramp(input logic [15:0] b);
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*16 +: 16] = b + 16'(i);
    return v;
  endfunction

  function automatic logic [W-1:0] splat(input logic [15:0] b);
    logic [W-1:0] v;
    for (int i = 0; i < COL; i++) v[i*16 +: 16] = b;
    return v;
  endfunction

  function automatic logic [W-1:0] wvec(input int k);
    return ramp(16'h1000 + 16'(k * 256));
  endfunction

  task automatic idle_inputs;
    start = 0; mode = 0; base_addr = 0; len = 0; in_valid = 0; in_data = '0;
    user_mode = 0; ext_cen = 1; ext_wen = 1; ext_addr = 0; ext_d = '0;
  endtask

  task automatic ext_write(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    user_mode = 1; ext_cen = 0; ext_wen = 0; ext_addr = a; ext_d = d;
    tick;
    user_mode = 0; ext_cen = 1; ext_wen = 1;
  endtask

  task automatic ext_read(input logic [ADDR_W-1:0] a, output logic [W-1:0] d, output logic v);
    user_mode = 1; ext_cen = 0; ext_wen = 1; ext_addr = a;
    tick;
    v = out_valid; d = out_data;
    user_mode = 0; ext_cen = 1; ext_wen = 1;
  endtask

  task automatic issue_start(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    start = 1; mode = m; base_addr = b; len = l;
    tick;
    start = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; start = 1; mode = 0; len = 4;
    tick; tick;
    reset = 0; idle_inputs();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
    n_total++; if (ovf !== '0) $display("FAIL reset_ovf: got %h want 0", ovf); else n_pass++;
  endtask

  task automatic test_user_mode;
    logic [W-1:0] d; logic v;
    ext_write(11'd5, ramp(16'h0001));
    ext_read(11'd5, d, v);
    n_total++; if (v !== 1'b1) $display("FAIL user_rd_valid: got %0b want 1", v); else n_pass++;
    n_total++; if (d !== ramp(16'h0001)) $display("FAIL user_rd_data: got %h want %h", d, ramp(16'h0001)); else n_pass++;
    tick;
    n_total++; if (out_valid !== 1'b0) $display("FAIL user_rd_valid_drop: got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_write_burst;
    logic [W-1:0] d; logic v; logic early;
    logic [ADDR_W-1:0] addrs [4];
    addrs[0] = 11'd2046; addrs[1] = 11'd2047; addrs[2] = 11'd0; addrs[3] = 11'd1;
    early = 0;
    in_valid = 1; in_data = wvec(0);
    issue_start(2'd0, 11'd2046, 12'd4);
    n_total++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL wr_enter: busy %0b ready %0b want 1 1", busy, in_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      in_data = wvec(k);
      if (done) early = 1;
      tick;
    end
    in_valid = 0;
    n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL wr_done_c5: done %0b busy %0b want 1 0", done, busy); else n_pass++;
    n_total++; if (early !== 1'b0) $display("FAIL wr_done_early: got %0b want 0", early); else n_pass++;
    tick;
    n_total++; if (done !== 1'b0) $display("FAIL wr_done_pulse: got %0b want 0", done); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      ext_read(addrs[k], d, v);
      n_total++; if (d !== wvec(k)) $display("FAIL wr_data_%0d: got %h want %h", k, d, wvec(k)); else n_pass++;
    end
  endtask

  task automatic test_accum;
    logic [W-1:0] d; logic v;
    ext_write(11'd3, splat(16'd100));
    in_valid = 1; in_data = splat(16'hFFE2);
    issue_start(2'd1, 11'd3, 12'd1);
    n_total++; if (in_ready !== 1'b1) $display("FAIL ac_ready_rd: got %0b want 1", in_ready); else n_pass++;
    tick;
    n_total++; if (in_ready !== 1'b0) $display("FAIL ac_ready_wb: got %0b want 0", in_ready); else n_pass++;
    in_valid = 0;
    tick;
    n_total++; if (done !== 1'b1) $display("FAIL ac_done: got %0b want 1", done); else n_pass++;
    n_total++; if (ovf !== 8'h00) $display("FAIL ac_ovf: got %h want 00", ovf); else n_pass++;
    ext_read(11'd3, d, v);
    n_total++; if (d !== splat(16'd70)) $display("FAIL ac_data: got %h want %h", d, splat(16'd70)); else n_pass++;
  endtask

  task automatic test_saturation;
    logic [W-1:0] p, a, e, d; logic v;
    p = '0; p[15:0] = 16'h7D00; p[127:112] = 16'h8000;
    a = '0; a[15:0] = 16'h03E8; a[127:112] = 16'hFFFF;
    e = '0; e[15:0] = 16'h7FFF; e[127:112] = 16'h8000;
    ext_write(11'd10, p);
    in_valid = 1; in_data = a;
    issue_start(2'd1, 11'd10, 12'd1);
    tick;
    in_valid = 0;
    tick;
    n_total++; if (ovf !== 8'h81) $display("FAIL sat_ovf: got %h want 81", ovf); else n_pass++;
    ext_read(11'd10, d, v);
    n_total++; if (d !== e) $display("FAIL sat_data: got %h want %h", d, e); else n_pass++;
    n_total++; if (ovf !== 8'h81) $display("FAIL sat_ovf_sticky: got %h want 81", ovf); else n_pass++;
    issue_start(2'd2, 11'd0, 12'd0);
    n_total++; if (ovf !== 8'h00) $display("FAIL sat_ovf_clear: got %h want 00", ovf); else n_pass++;
    tick;
  endtask

  task automatic test_read;
    issue_start(2'd2, 11'd2046, 12'd3);
    n_total++; if (out_valid !== 1'b0) $display("FAIL rd_c1_valid: got %0b want 0", out_valid); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_total++; if (out_valid !== 1'b1 || out_data !== wvec(k)) $display("FAIL rd_c%0d_data: valid %0b data %h want 1 %h", k+2, out_valid, out_data, wvec(k)); else n_pass++;
      n_total++; if (done !== (k == 2)) $display("FAIL rd_c%0d_done: got %0b want %0b", k+2, done, (k == 2)); else n_pass++;
    end
    tick;
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rd_c5_idle: valid %0b busy %0b want 0 0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_len_zero;
    issue_start(2'd2, 11'd5, 12'd0);
    n_total++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL len0_c1: done %0b busy %0b valid %0b want 1 0 0", done, busy, out_valid); else n_pass++;
    tick;
    n_total++; if (done !== 1'b0 || out_valid !== 1'b0) $display("FAIL len0_c2: done %0b valid %0b want 0 0", done, out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    logic [W-1:0] d; logic v; logic seen;
    seen = 0;
    issue_start(2'd2, 11'd2046, 12'd8);
    tick;
    reset = 1;
    tick;
    reset = 0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_state: busy %0b done %0b want 0 0", busy, done); else n_pass++;
    n_total++; if (out_valid !== 1'b0 || out_data !== '0) $display("FAIL rst_mid_out: valid %0b data %h want 0 0", out_valid, out_data); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (done || out_valid) seen = 1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rst_mid_quiet: got %0b want 0", seen); else n_pass++;
    ext_read(11'd2046, d, v);
    n_total++; if (d !== wvec(0)) $display("FAIL rst_mid_keep0: got %h want %h", d, wvec(0)); else n_pass++;
    ext_read(11'd1, d, v);
    n_total++; if (d !== wvec(3)) $display("FAIL rst_mid_keep3: got %h want %h", d, wvec(3)); else n_pass++;
  endtask

  task automatic test_ignored;
    logic [W-1:0] d; logic v;
    ext_write(11'd50, splat(16'h5555));
    issue_start(2'd0, 11'd20, 12'd2);
    start = 1; mode = 2'd2; base_addr = 11'd100; len = 12'd5;
    user_mode = 1; ext_cen = 0; ext_wen = 0; ext_addr = 11'd50; ext_d = splat(16'hDEAD);
    tick;
    idle_inputs();
    n_total++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL ign_still_wr: busy %0b ready %0b want 1 1", busy, in_ready); else n_pass++;
    in_valid = 1; in_data = splat(16'hA0A0);
    tick;
    in_data = splat(16'hB0B0);
    tick;
    in_valid = 0;
    n_total++; if (done !== 1'b1) $display("FAIL ign_done: got %0b want 1", done); else n_pass++;
    tick;
    ext_read(11'd20, d, v);
    n_total++; if (d !== splat(16'hA0A0)) $display("FAIL ign_data20: got %h want %h", d, splat(16'hA0A0)); else n_pass++;
    ext_read(11'd21, d, v);
    n_total++; if (d !== splat(16'hB0B0)) $display("FAIL ign_data21: got %h want %h", d, splat(16'hB0B0)); else n_pass++;
    ext_read(11'd50, d, v);
    n_total++; if (d !== splat(16'h5555)) $display("FAIL ign_data50: got %h want %h", d, splat(16'h5555)); else n_pass++;
    issue_start(2'd3, 11'd0, 12'd2);
    n_total++; if (busy !== 1'b0) $display("FAIL ign_mode3_busy: got %0b want 0", busy); else n_pass++;
    tick;
    n_total++; if (done !== 1'b0) $display("FAIL ign_mode3_done: got %0b want 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    issue_start(2'd2, 11'd2046, 12'd1);
    tick;
    n_total++; if (done !== 1'b1 || out_data !== wvec(0)) $display("FAIL b2b_first: done %0b data %h want 1 %h", done, out_data, wvec(0)); else n_pass++;
    issue_start(2'd2, 11'd2047, 12'd1);
    n_total++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_accept: busy %0b valid %0b want 1 0", busy, out_valid); else n_pass++;
    tick;
    n_total++; if (out_valid !== 1'b1 || done !== 1'b1 || out_data !== wvec(1)) $display("FAIL b2b_second: valid %0b done %0b data %h want 1 1 %h", out_valid, done, out_data, wvec(1)); else n_pass++;
    tick;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_user_mode();
    test_write_burst();
    test_accum();
    test_saturation();
    test_read();
    test_len_zero();
    test_reset_mid_read();
    test_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
